// File: rtl/wm_pkg.sv
// Shared types for the wash cycle sequencer: phase encoding, programme codes
// and the per-programme rinse/heat configuration.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_HEAT  = 3'd2,
    ST_WASH  = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_FAULT = 3'd6,
    ST_DONE  = 3'd7
  } wm_state_t;

  localparam logic [1:0] PROG_QUICK  = 2'd0;
  localparam logic [1:0] PROG_NORMAL = 2'd1;
  localparam logic [1:0] PROG_HEAVY  = 2'd2;

  typedef struct packed {
    logic       heat_en;
    logic [1:0] rinses;
  } prog_cfg_t;

  // Code 3 is not a programme of its own and behaves as normal.
  function automatic prog_cfg_t prog_cfg(input logic [1:0] prog);
    prog_cfg_t cfg;
    case (prog)
      PROG_QUICK: cfg = '{heat_en: 1'b0, rinses: 2'd1};
      PROG_HEAVY: cfg = '{heat_en: 1'b1, rinses: 2'd3};
      default:    cfg = '{heat_en: 1'b1, rinses: 2'd2};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: a TICK_DIV prescaler feeding an 8-bit unit down-counter.
// A load restarts the phase; hold freezes both counters.
module phase_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] duration,
  input  logic       hold,
  output logic       tick,
  output logic       expire,
  output logic [7:0] remaining
);

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

  logic [7:0] presc_reg;
  logic [7:0] remaining_reg;

  if (TICK_DIV < 1 || TICK_DIV > 255) begin : g_bad_tick_div
    $error("phase_timer: TICK_DIV must lie in 1..255");
  end

  // An exhausted counter never ticks, so an idle timer stays quiet.
  assign tick      = !hold && (remaining_reg != 8'd0) && (presc_reg == PRESC_LAST);
  assign expire    = tick && (remaining_reg == 8'd1);
  assign remaining = remaining_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg     <= 8'd0;
      remaining_reg <= 8'd0;
    end else if (load) begin
      presc_reg     <= 8'd0;
      remaining_reg <= duration;
    end else if (!hold && remaining_reg != 8'd0) begin
      if (presc_reg == PRESC_LAST) begin
        presc_reg     <= 8'd0;
        remaining_reg <= remaining_reg - 8'd1;
      end else begin
        presc_reg <= presc_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash programme sequencer: walks FILL, HEAT, WASH, RINSE xN, SPIN for the
// latched programme, with lid pause, cancel and sticky fault handling.
module wash_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int FILL_TIME  = 3,
  parameter int HEAT_TIME  = 4,
  parameter int WASH_TIME  = 6,
  parameter int RINSE_TIME = 4,
  parameter int SPIN_TIME  = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sig_Start,
  input  logic [1:0] program_sel,
  input  logic       sig_Lid_Closed,
  input  logic       sig_Cancel,
  input  logic       sig_Fault,
  input  logic       fault_Clear,
  output logic [2:0] state,
  output logic       busy,
  output logic       water_Valve,
  output logic       heater_On,
  output logic       motor_On,
  output logic [1:0] rinse_Count,
  output logic [7:0] remaining,
  output logic       phase_Done,
  output logic       cycle_Done
);

  if (2 * WASH_TIME > 255 || FILL_TIME > 255 || HEAT_TIME > 255 ||
      RINSE_TIME > 255 || SPIN_TIME > 255) begin : g_bad_duration
    $error("wash_cycle_sequencer: phase durations must fit in 8 bits");
  end

  localparam logic [7:0] FILL_UNITS   = 8'(FILL_TIME);
  localparam logic [7:0] HEAT_UNITS   = 8'(HEAT_TIME);
  localparam logic [7:0] WASH_UNITS   = 8'(WASH_TIME);
  localparam logic [7:0] WASH2_UNITS  = 8'(2 * WASH_TIME);
  localparam logic [7:0] RINSE_UNITS  = 8'(RINSE_TIME);
  localparam logic [7:0] SPIN_UNITS   = 8'(SPIN_TIME);

  wm_state_t  state_reg, state_next;
  logic [1:0] prog_reg, prog_next;
  logic [1:0] rinse_count_reg, rinse_count_next;

  prog_cfg_t  cfg;
  logic [7:0] wash_units;
  logic [2:0] rinse_done;
  logic       is_timed;
  logic       timer_load;
  logic [7:0] timer_duration;
  logic       timer_hold;
  logic       unit_tick;
  logic       timer_expire;
  logic       phase_end;
  logic [7:0] timer_remaining;

  assign cfg        = prog_cfg(prog_reg);
  assign wash_units = (prog_reg == PROG_HEAVY) ? WASH2_UNITS : WASH_UNITS;
  assign rinse_done = {1'b0, rinse_count_reg} + 3'd1;
  assign is_timed   = (state_reg >= ST_FILL) && (state_reg <= ST_SPIN);
  assign timer_hold = !is_timed || !sig_Lid_Closed;
  assign phase_end  = unit_tick && timer_expire;

  phase_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_phase_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (timer_load),
    .duration  (timer_duration),
    .hold      (timer_hold),
    .tick      (unit_tick),
    .expire    (timer_expire),
    .remaining (timer_remaining)
  );

  // Next-phase decode; every phase change reloads the timer in the same edge.
  always_comb begin
    state_next       = state_reg;
    prog_next        = prog_reg;
    rinse_count_next = rinse_count_reg;
    timer_load       = 1'b0;
    timer_duration   = 8'd0;
    case (state_reg)
      ST_IDLE: begin
        if (sig_Start && sig_Lid_Closed) begin
          state_next       = ST_FILL;
          prog_next        = program_sel;
          rinse_count_next = 2'd0;
          timer_load       = 1'b1;
          timer_duration   = FILL_UNITS;
        end
      end
      ST_FAULT: begin
        if (fault_Clear && !sig_Fault) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        if (sig_Fault) begin
          state_next = ST_FAULT;
          timer_load = 1'b1;
        end else if (sig_Cancel) begin
          state_next = ST_IDLE;
          timer_load = 1'b1;
        end else if (phase_end) begin
          timer_load = 1'b1;
          case (state_reg)
            ST_FILL: begin
              if (cfg.heat_en) begin
                state_next     = ST_HEAT;
                timer_duration = HEAT_UNITS;
              end else begin
                state_next     = ST_WASH;
                timer_duration = wash_units;
              end
            end
            ST_HEAT: begin
              state_next     = ST_WASH;
              timer_duration = wash_units;
            end
            ST_WASH: begin
              state_next     = ST_RINSE;
              timer_duration = RINSE_UNITS;
            end
            ST_RINSE: begin
              rinse_count_next = rinse_done[1:0];
              if (rinse_done < {1'b0, cfg.rinses}) begin
                state_next     = ST_RINSE;
                timer_duration = RINSE_UNITS;
              end else begin
                state_next     = ST_SPIN;
                timer_duration = SPIN_UNITS;
              end
            end
            default: begin
              state_next = ST_DONE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      prog_reg        <= PROG_NORMAL;
      rinse_count_reg <= 2'd0;
    end else begin
      state_reg       <= state_next;
      prog_reg        <= prog_next;
      rinse_count_reg <= rinse_count_next;
    end
  end

  // Outputs decode the registered phase; an open lid gates every actuator.
  assign state       = state_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign water_Valve = (state_reg == ST_FILL) && sig_Lid_Closed;
  assign heater_On   = (state_reg == ST_HEAT) && sig_Lid_Closed;
  assign motor_On    = ((state_reg == ST_WASH) || (state_reg == ST_RINSE) ||
                        (state_reg == ST_SPIN)) && sig_Lid_Closed;
  assign rinse_Count = rinse_count_reg;
  assign remaining   = timer_remaining;
  assign phase_Done  = phase_end && (sig_Fault || !sig_Cancel);
  assign cycle_Done  = (state_reg == ST_DONE);

endmodule

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

Sequences one complete wash programme through the fill, heat, wash, rinse and spin phases. It times each phase with a prescaled tick and drives the valve, heater and motor enables. It sits between the user-facing `Controller` (start, cancel, lid, fault inputs) and the phase-timing path. It replaces fixed phase ordering with a latched programme selection that sets heat inclusion, wash length and rinse repetitions.

## Interface
Parameters:
- `TICK_DIV`, default 4: clock cycles per time unit; legal range 1..255.
- `FILL_TIME`, default 3: fill phase length in units.
- `HEAT_TIME`, default 4: heat phase length in units.
- `WASH_TIME`, default 6: wash phase length in units; doubled for programme 2.
- `RINSE_TIME`, default 4: length of each rinse pass in units.
- `SPIN_TIME`, default 5: spin phase length in units.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sig_Start`  in  1  start request; sampled only in IDLE.
- `program`  in  2  programme select: 0 quick, 1 normal, 2 heavy, 3 treated as normal.
- `sig_Lid_Closed`  in  1  lid state; low pauses an active phase.
- `sig_Cancel`  in  1  abort the current cycle.
- `sig_Fault`  in  1  motor failure or out-of-balance (OR'd upstream).
- `fault_Clear`  in  1  operator acknowledge of a fault.
- `state`  out  3  current phase encoding.
- `busy`  out  1  high in every state except IDLE.
- `water_Valve`  out  1  high in FILL while not paused.
- `heater_On`  out  1  high in HEAT while not paused.
- `motor_On`  out  1  high in WASH, RINSE and SPIN while not paused.
- `rinse_Count`  out  2  rinse passes completed in this cycle.
- `remaining`  out  8  units left in the current phase.
- `phase_Done`  out  1  one-cycle pulse on every timed phase exit.
- `cycle_Done`  out  1  one-cycle pulse while in DONE.

## Operation
- **State encoding:** IDLE=0, FILL=1, HEAT=2, WASH=3, RINSE=4, SPIN=5, FAULT=6, DONE=7.
- **Start:** in IDLE, `sig_Start`=1 with `sig_Lid_Closed`=1 latches `program`, clears `rinse_Count` and enters FILL. A start with the lid open is ignored.
- **Programme parameters:**
  - 0 (quick): no HEAT, 1 rinse, wash = `WASH_TIME`.
  - 1 (normal): HEAT, 2 rinses, wash = `WASH_TIME`.
  - 2 (heavy): HEAT, 3 rinses, wash = 2×`WASH_TIME`.
- **Phase order:** FILL → HEAT (skipped for quick) → WASH → RINSE, repeated N times → SPIN → DONE → IDLE.
- **RINSE repetition:** on each RINSE expiry, `rinse_Count` increments. If `rinse_Count`+1 < N, the sequencer re-enters RINSE and reloads `remaining`; otherwise it goes to SPIN.
- **Phase entry:** `remaining` loads the phase duration and the prescaler clears to 0.
- **Prescaler:** counts 0..`TICK_DIV`-1. A tick occurs at `TICK_DIV`-1, and each tick decrements `remaining`.
- **Phase expiry:** a tick with `remaining`=1 ends the phase. `phase_Done` pulses in that cycle, and the next state is taken at the same edge.
- **Pause:** while `sig_Lid_Closed`=0 in FILL through SPIN, the prescaler and `remaining` hold and all actuator outputs are 0. The state does not change.
- **Priority** (highest first): reset, `sig_Fault`, `sig_Cancel`, pause, tick.
- **Fault:** `sig_Fault`=1 in any state except IDLE and DONE enters FAULT. All actuators are off and `remaining` is 0.
  - FAULT is sticky. It exits to IDLE only when `fault_Clear`=1 and `sig_Fault`=0 in the same cycle.
- **Cancel:** `sig_Cancel`=1 in FILL through SPIN returns to IDLE at the next edge. `cycle_Done` does not pulse and `rinse_Count` holds its value until the next start.
- **DONE:** lasts exactly one cycle, then the sequencer goes to IDLE.
- **Arithmetic:** `remaining` is 8 bits. The 2×`WASH_TIME` product must fit in 8 bits; this is checked by an elaboration-time assertion.

## Timing
- **Reset values:** `state`=IDLE. `busy`, `water_Valve`, `heater_On`, `motor_On`, `phase_Done` and `cycle_Done` are 0. `rinse_Count`=0, `remaining`=0, prescaler=0, latched programme=1.
- **Start latency:** `sig_Start` at edge k puts `state`=FILL after edge k. `water_Valve` rises in the same cycle, since outputs are decoded from registered state.
- **Phase length:** an unpaused phase lasts exactly duration×`TICK_DIV` cycles. Paused cycles add one-for-one.
- **Pause release:** resumes at the held prescaler value, with no extra cycle.
- **Fault versus expiry:** a fault asserted in the same cycle as phase expiry wins. `phase_Done` still pulses, but the next state is FAULT.
- **Cancel versus expiry:** cancel wins over expiry and `phase_Done` is suppressed.
- **Start in DONE:** ignored, because the sequencer must pass through IDLE first.
- **Reset mid-cycle:** immediate asynchronous return to the reset values.

## Structure
- Shared package `wm_pkg` holds:
  - the 3-bit state enum with the encodings above;
  - programme codes;
  - a function returning the rinse count and heat-enable flag for a given programme.
- Sub-module `phase_timer` holds the prescaler and the `remaining` down-counter.
  - Inputs: load, duration, hold.
  - Outputs: tick, expire.
  - The sequencer FSM instantiates it once.

## Test plan
- **Quick programme:** `TICK_DIV`=4, program 0, start with lid closed → FILL 12, WASH 24, RINSE 16 and SPIN 20 cycles. HEAT is never entered, `cycle_Done` pulses once at cycle 73 and `rinse_Count`=1.
- **Heavy programme:** program 2 → HEAT 16 cycles, WASH 48 cycles, three RINSE passes. `phase_Done` pulses 7 times in total and `rinse_Count` ends at 3.
- **Lid pause:** lid opened for 10 cycles mid-WASH → all actuators are 0 and `remaining` holds. WASH lasts 34 cycles in total, not 24.
- **Fault handling:** fault in RINSE → FAULT next edge. Raising `fault_Clear` while `sig_Fault` is still 1 has no effect; after `sig_Fault` drops, `fault_Clear` → IDLE.
- **Cancel at expiry:** cancel on the expiry cycle of HEAT → IDLE, with no `phase_Done` and no `cycle_Done`.
- **Reset and ignored start:** `reset_n` low during SPIN → all outputs return to reset values asynchronously. A start with the lid open is ignored.
